// File: rtl/scaler_readout_sequencer.sv
// Wishbone reader that drains a block of scaler words after each scaler update
// and emits it as a framed 32-bit stream. Optional feature macro: SCALER_RDSEQ_TSTAMP_EN.
module scaler_readout_sequencer #(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int unsigned MAX_WORDS = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        trig_i,
    input  logic [5:0]  nwords_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy_o,
    output logic [15:0] seq_o,
    output logic [15:0] overrun_o,
    output logic [15:0] buserr_o
);

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [5:0]  MAX_N    = 6'(MAX_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [31:0] BAD_WORD = 32'hDEADDEAD;
`ifdef SCALER_RDSEQ_TSTAMP_EN
    localparam logic [1:0]  HDR_FLAGS = 2'b01;
`else
    localparam logic [1:0]  HDR_FLAGS = 2'b00;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_PUSH    = 3'd4,
        S_DONE    = 3'd5
`ifdef SCALER_RDSEQ_TSTAMP_EN
        , S_TS    = 3'd6
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     n_q, n_d;
    logic [5:0]     k_q, k_d;
    logic [15:0]    seq_cnt_q, seq_cnt_d;
    logic [15:0]    seq_q, seq_d;
    logic [15:0]    ovr_q, ovr_d;
    logic [15:0]    berr_q, berr_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           cyc_q, cyc_d;
    logic [15:0]    adr_q, adr_d;
    logic [31:0]    tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d;
    logic           tlast_q, tlast_d;
    logic           busy_q, busy_d;
    logic           trig_ok_s;
    logic           hs_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] word_addr(input logic [5:0] k);
        return BASE_ADDR + {8'h00, k, 2'b00};
    endfunction

    assign trig_ok_s = trig_i & enable_i;
    assign hs_s      = tvalid_q & m_tready;

`ifdef SCALER_RDSEQ_TSTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    // Free-running cycle counter, captured on the accepted trigger.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_cnt_q <= 32'd0;
            ts_q     <= 32'd0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (state_q == S_IDLE && trig_ok_s) begin
                ts_q <= ts_cnt_q;
            end else begin
                ts_q <= ts_q;
            end
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            n_q       <= 6'd0;
            k_q       <= 6'd0;
            seq_cnt_q <= 16'd0;
            seq_q     <= 16'd0;
            ovr_q     <= 16'd0;
            berr_q    <= 16'd0;
            tmo_q     <= '0;
            cyc_q     <= 1'b0;
            adr_q     <= 16'd0;
            tdata_q   <= 32'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            seq_cnt_q <= seq_cnt_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
            berr_q    <= berr_d;
            tmo_q     <= tmo_d;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        seq_cnt_d = seq_cnt_q;
        seq_d     = seq_q;
        ovr_d     = ovr_q;
        berr_d    = berr_q;
        tmo_d     = tmo_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;

        // Any enabled trigger outside IDLE (DONE included) is lost.
        if (trig_ok_s && state_q != S_IDLE) begin
            ovr_d = sat_inc16(ovr_q);
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (trig_ok_s) begin
                    n_d      = (nwords_i > MAX_N) ? MAX_N : nwords_i;
                    k_d      = 6'd0;
                    busy_d   = 1'b1;
                    tvalid_d = 1'b1;
                    tdata_d  = {8'hA5, HDR_FLAGS, n_d, seq_cnt_q};
`ifdef SCALER_RDSEQ_TSTAMP_EN
                    tlast_d  = 1'b0;
`else
                    tlast_d  = (n_d == 6'd0);
`endif
                    state_d  = S_HDR;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_HDR: begin
                if (hs_s) begin
`ifdef SCALER_RDSEQ_TSTAMP_EN
                    tdata_d  = ts_q;
                    tlast_d  = (n_q == 6'd0);
                    tvalid_d = 1'b1;
                    state_d  = S_TS;
`else
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (n_q == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        adr_d   = word_addr(k_q);
                        state_d = S_RD_REQ;
                    end
`endif
                end else begin
                    state_d = S_HDR;
                end
            end
`ifdef SCALER_RDSEQ_TSTAMP_EN
            S_TS: begin
                if (hs_s) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (n_q == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        adr_d   = word_addr(k_q);
                        state_d = S_RD_REQ;
                    end
                end else begin
                    state_d = S_TS;
                end
            end
`endif
            S_RD_REQ: begin
                cyc_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Ack wins over a simultaneous error or timeout.
                if (wbm_ack_i) begin
                    tdata_d  = wbm_dat_i;
                    cyc_d    = 1'b0;
                    tvalid_d = 1'b1;
                    tlast_d  = (k_q == n_q - 6'd1);
                    state_d  = S_PUSH;
                end else if (wbm_err_i || tmo_q >= TMO_LAST) begin
                    tdata_d  = BAD_WORD;
                    berr_d   = sat_inc16(berr_q);
                    cyc_d    = 1'b0;
                    tvalid_d = 1'b1;
                    tlast_d  = (k_q == n_q - 6'd1);
                    state_d  = S_PUSH;
                end else begin
                    tmo_d    = tmo_q + TMO_ONE;
                    state_d  = S_RD_WAIT;
                end
            end
            S_PUSH: begin
                if (hs_s) begin
                    k_d      = k_q + 6'd1;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        state_d = S_DONE;
                    end else begin
                        adr_d   = word_addr(k_d);
                        state_d = S_RD_REQ;
                    end
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_DONE: begin
                seq_d     = seq_cnt_q;
                seq_cnt_d = seq_cnt_q + 16'd1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                cyc_d    = 1'b0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = adr_q;
    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign m_tlast   = tlast_q;
    assign busy_o    = busy_q;
    assign seq_o     = seq_q;
    assign overrun_o = ovr_q;
    assign buserr_o  = berr_q;

endmodule

// File: tb/tb_scaler_readout_sequencer.sv
// Self-checking bench for scaler_readout_sequencer: table of frames against a
// Wishbone slave model and a stream scoreboard, plus hand-written corner cases.
module tb_scaler_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i, trig_i;
    logic [5:0]  nwords_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [15:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic        busy_o;
    logic [15:0] seq_o, overrun_o, buserr_o;

    scaler_readout_sequencer dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .trig_i(trig_i), .nwords_i(nwords_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
        .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy_o(busy_o), .seq_o(seq_o), .overrun_o(overrun_o), .buserr_o(buserr_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    logic [15:0] exp_adr_q[$];
    logic [15:0] exp_seq = 16'd0;
    logic [15:0] exp_berr = 16'd0;
    logic [15:0] exp_ovr = 16'd0;
    int slv_lat = 2;
    bit slv_err = 1'b0;
    int stall_word = -1;
    int stall_len = 0;
    int word_idx = 0;

    typedef struct {
        int nw;
        int lat;
        bit errm;
        int sw;
        int sl;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    // Wishbone slave: responds after slv_lat cycles of cyc&stb (0 = never).
    initial begin : slave
        int cnt;
        cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                cnt++;
                if (cnt == 1) begin
                    if (exp_adr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL wb_extra_read: got adr %04h expected no read", wbm_adr_o);
                    end else begin
                        check("wb_adr", {16'h0, wbm_adr_o}, {16'h0, exp_adr_q.pop_front()});
                    end
                    check("wb_we_sel", {27'h0, wbm_we_o, wbm_sel_o}, 32'h0000000F);
                end
                if (slv_lat != 0 && cnt == slv_lat) begin
                    if (slv_err) wbm_err_i = 1'b1;
                    else begin wbm_ack_i = 1'b1; wbm_dat_i = slv_data(wbm_adr_o); end
                end else begin
                    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
                end
            end else begin
                if (cnt != 0 && slv_lat == 0) check("timeout_len", cnt, 32'd255);
                cnt = 0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            end
        end
    end

    // Downstream ready: high except for one programmed stall.
    initial begin : ready_gen
        int left;
        left = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (left > 0) begin
                m_tready = 1'b0; left--;
            end else if (stall_word >= 0 && m_tvalid && word_idx == stall_word) begin
                m_tready = 1'b0; left = stall_len - 1; stall_word = -1;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // Stream monitor and scoreboard.
    initial begin : monitor
        logic [32:0] e;
        logic [31:0] held;
        logic held_last;
        bit stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0; word_idx = 0;
            end else begin
                if (m_tvalid && !m_tready) begin
                    if (stalled) begin
                        check("stall_tdata", m_tdata, held);
                        check("stall_tlast", {31'h0, m_tlast}, {31'h0, held_last});
                        check("stall_no_wb", {31'h0, wbm_cyc_o}, 32'h0);
                    end
                    stalled = 1'b1; held = m_tdata; held_last = m_tlast;
                end else begin
                    stalled = 1'b0;
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL stream_extra: got %08h expected no word", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_data", m_tdata, e[31:0]);
                        check("stream_last", {31'h0, m_tlast}, {31'h0, e[32]});
                    end
                    word_idx = m_tlast ? 0 : word_idx + 1;
                end
            end
        end
    end

    task automatic expect_frame(input int nw, input int lat, input bit errm);
        int n;
        logic [15:0] a;
        bit bad;
        n = (nw > 32) ? 32 : nw;
        bad = (lat == 0) || errm;
        nwords_i = 6'(nw);
        slv_lat = lat;
        slv_err = errm;
        exp_q.push_back({(n == 0), 8'hA5, 2'b00, 6'(n), exp_seq});
        for (int k = 0; k < n; k++) begin
            a = 16'h0800 + 16'(4 * k);
            exp_adr_q.push_back(a);
            exp_q.push_back({(k == n - 1), bad ? 32'hDEADDEAD : slv_data(a)});
        end
        if (bad) exp_berr = exp_berr + 16'(n);
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1; trig_i = 1'b1;
        @(posedge clk); #1; trig_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((busy_o || exp_q.size() != 0) && c < budget) begin
            @(posedge clk); #1; c++;
        end
        check("frame_done_in_time", {31'h0, (c < budget)}, 32'h1);
    endtask

    task automatic check_status();
        check("seq_o", {16'h0, seq_o}, {16'h0, exp_seq});
        exp_seq = exp_seq + 16'd1;
        check("buserr_o", {16'h0, buserr_o}, {16'h0, exp_berr});
        check("overrun_o", {16'h0, overrun_o}, {16'h0, exp_ovr});
        check("words_left", exp_q.size(), 32'd0);
        check("reads_left", exp_adr_q.size(), 32'd0);
    endtask

    task automatic run_frame(input int nw, input int lat, input bit errm);
        expect_frame(nw, lat, errm);
        pulse_trig();
        wait_done(20000);
        check_status();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        rst = 1'b1; enable_i = 1'b0; trig_i = 1'b0; nwords_i = 6'd0;
        vecs[0] = '{nw: 4,  lat: 2, errm: 1'b0, sw: -1, sl: 0};
        vecs[1] = '{nw: 0,  lat: 2, errm: 1'b0, sw: -1, sl: 0};
        vecs[2] = '{nw: 2,  lat: 0, errm: 1'b0, sw: -1, sl: 0};
        vecs[3] = '{nw: 1,  lat: 1, errm: 1'b0, sw: -1, sl: 0};
        vecs[4] = '{nw: 3,  lat: 2, errm: 1'b0, sw: 2,  sl: 20};
        vecs[5] = '{nw: 40, lat: 1, errm: 1'b0, sw: -1, sl: 0};
        vecs[6] = '{nw: 5,  lat: 3, errm: 1'b1, sw: -1, sl: 0};
        vecs[7] = '{nw: 32, lat: 2, errm: 1'b0, sw: 0,  sl: 3};

        repeat (3) @(posedge clk); #1;
        check("rst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        check("rst_adr", {16'h0, wbm_adr_o}, 32'h0);
        check("rst_stream", {30'h0, m_tvalid, m_tlast}, 32'h0);
        check("rst_tdata", m_tdata, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_counters", {seq_o, overrun_o | buserr_o}, 32'h0);
        rst = 1'b0; enable_i = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            stall_word = vecs[i].sw;
            stall_len  = vecs[i].sl;
            run_frame(vecs[i].nw, vecs[i].lat, vecs[i].errm);
        end

        // Second trigger five cycles into a frame is dropped and counted.
        expect_frame(8, 2, 1'b0);
        pulse_trig();
        repeat (3) @(posedge clk);
        pulse_trig();
        exp_ovr = exp_ovr + 16'd1;
        wait_done(20000);
        check_status();
        repeat (10) @(posedge clk); #1;
        check("no_second_frame", {31'h0, busy_o}, 32'h0);

        // Trigger with enable low is ignored and not counted.
        enable_i = 1'b0;
        pulse_trig();
        repeat (5) @(posedge clk); #1;
        check("disabled_trig_busy", {31'h0, busy_o}, 32'h0);
        check("disabled_trig_ovr", {16'h0, overrun_o}, {16'h0, exp_ovr});

        // Enable falling mid-frame lets the frame complete.
        enable_i = 1'b1;
        expect_frame(3, 2, 1'b0);
        pulse_trig();
        enable_i = 1'b0;
        wait_done(20000);
        check_status();
        enable_i = 1'b1;

        // Reset while a read is outstanding.
        expect_frame(2, 0, 1'b0);
        pulse_trig();
        c = 0;
        while (!wbm_cyc_o && c < 50) begin @(posedge clk); #1; c++; end
        check("cyc_before_reset", {31'h0, wbm_cyc_o}, 32'h1);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        check("arst_stream", {30'h0, m_tvalid, m_tlast}, 32'h0);
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        check("arst_counters", {seq_o, buserr_o}, 32'h0);
        exp_q.delete();
        exp_adr_q.delete();
        exp_seq = 16'd0; exp_berr = 16'd0; exp_ovr = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(1, 2, 1'b0);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scaler_readout_sequencer.md
Name: scaler_readout_sequencer

Overview:
- Wishbone master that reads a block of dual-packed scaler words from the scaler block after each scaler update.
- Emits the words as a framed 32-bit stream (valid/ready, last) to the event/housekeeping buffer.
- Sits between the scaler block's WB slave port (via the WB interconnect) and the downstream event formatter.
- Owns frame sequencing, overrun accounting and bus-timeout recovery.

Parameters:
- BASE_ADDR, 16'h0800, WB byte address of the first scaler readback word (scaler window, bit 11 set).
- MAX_WORDS, 32, maximum words per frame; nwords_i is clamped to this value.
- TIMEOUT, 255, cycles to wait for wbm_ack_i before abandoning a read.

Ports:
- clk_i  in  1  system clock (50 MHz domain)
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  arms the sequencer; triggers are ignored while low
- trig_i  in  1  single-cycle pulse: scalers have just updated
- nwords_i  in  6  number of scaler words per frame; sampled on the accepted trigger
- wbm_cyc_o  out  1  WB cycle
- wbm_stb_o  out  1  WB strobe
- wbm_we_o  out  1  WB write enable; always 0
- wbm_adr_o  out  16  WB byte address
- wbm_sel_o  out  4  WB byte select; always 4'hF
- wbm_dat_i  in  32  WB read data
- wbm_ack_i  in  1  WB acknowledge
- wbm_err_i  in  1  WB error
- m_tdata  out  32  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  last word of frame
- busy_o  out  1  frame in progress
- seq_o  out  16  frame sequence number of the last completed frame
- overrun_o  out  16  saturating count of dropped triggers
- buserr_o  out  16  saturating count of WB errors plus timeouts

Behaviour:
- Reset (asynchronous, rst_i=1): all outputs 0, state IDLE, internal sequence counter 0.
- Clock and reset naming and polarity are fixed: single clock clk_i, reset rst_i asynchronous and active-high.
- States: IDLE, HDR, RD_REQ, RD_WAIT, PUSH, DONE.
- IDLE:
  - On trig_i && enable_i, latch n = min(nwords_i, MAX_WORDS), set k=0, busy_o=1.
  - Go to HDR.
- HDR:
  - Present m_tdata = {8'hA5, 2'b00, n[5:0], seq_cnt[15:0]} with m_tvalid=1.
  - m_tlast=1 iff n==0.
  - On handshake (tvalid&&tready): go to DONE if n==0, else RD_REQ.
- RD_REQ: assert cyc/stb with adr = BASE_ADDR + 4*k; go to RD_WAIT the same cycle.
- RD_WAIT:
  - Hold cyc/stb until ack, err or timeout.
  - On ack: latch wbm_dat_i, drop cyc/stb the next cycle, go to PUSH.
  - On err or timeout (TIMEOUT cycles with no ack): latch 32'hDEADDEAD, increment buserr_o (saturating at 16'hFFFF), drop cyc/stb, go to PUSH.
- PUSH:
  - Present the latched word with m_tlast = (k==n-1).
  - m_tdata, m_tvalid and m_tlast stay stable until the handshake.
  - On handshake: k++; go to DONE if the word was last, else RD_REQ.
- DONE: seq_o <= seq_cnt; seq_cnt++ (wraps at 16 bits); busy_o=0; return to IDLE.
- Only one WB transaction is ever outstanding. The next read is not issued until the previous word is accepted downstream, so no FIFO is needed.
- Trigger while busy (state != IDLE): the trigger is dropped and overrun_o increments (saturates). A trigger coinciding with the DONE cycle also counts as an overrun.
- Trigger while enable_i=0: ignored and not counted.
- enable_i falling mid-frame: the current frame still completes.
- Latency:
  - trig_i to header valid: 1 cycle.
  - ack to data valid: 1 cycle.
  - Minimum per-word cost with ack in 2 cycles and tready held high: 4 cycles.
- Reset mid-frame: the bus is released immediately (cyc/stb low) and the stream drops tvalid with no tlast. The downstream consumer discards the partial frame on reset.

Optional Feature:
- SCALER_RDSEQ_TSTAMP_EN: a free-running 32-bit cycle counter is latched on the accepted trigger and emitted as a second word immediately after the header.
  - Header bits [23:22] = 2'b01.
  - If n==0, the timestamp word carries m_tlast instead of the header.
- Without the macro: no counter, header bits [23:22] = 2'b00, frame length = n+1.

Test Plan:
- nwords_i=4, ack after 2 cycles, tready=1, one trigger:
  - Reads 0x0800/0x0804/0x0808/0x080C.
  - Stream is A5040000, d0..d3, tlast on d3.
  - seq_o=0 afterwards.
- nwords_i=0:
  - Single word A5000000 with tlast.
  - No WB activity.
  - seq_o increments.
- nwords_i=2, never ack:
  - Each read times out after 255 cycles.
  - Stream is header, DEADDEAD, DEADDEAD.
  - buserr_o=2.
- nwords_i=8, second trigger 5 cycles after the first:
  - overrun_o=1.
  - Exactly one frame of 9 words.
- nwords_i=3, tready low for 20 cycles on the second data word:
  - tdata held stable.
  - No new WB cycle during the stall.
  - Frame intact.
- rst_i asserted during RD_WAIT:
  - cyc/stb/tvalid drop asynchronously.
  - The next trigger produces a header with seq 0.
